// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes op requests into 32-bit words, buffers them and streams them to instruction memory.
// Optional ILLEGAL_TRAP_EN: illegal op ids are dropped and flagged instead of being encoded as addp.
module instr_encoder_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [4:0]                 req_op,
    input  logic [3:0]                 req_rd,
    input  logic [3:0]                 req_rs1,
    input  logic [3:0]                 req_rs2,
    input  logic [14:0]                req_imm,
    input  logic                       base_load,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       mem_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [15:0]                wr_count,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       err_illegal
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [2:0]        opc;
    logic [1:0]        f2;
    logic              illegal, jump, drop, acc, push, pop;
    logic [3:0]        rd, rs1, rs2;
    logic [14:0]       imm;
    logic [31:0]       word;
    logic [31:0]       fifo_q [DEPTH];
    logic [31:0]       fifo_d [DEPTH];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       wc_q, wc_d;
    logic              err_q, err_d;

    always_comb begin
        illegal = 1'b0;
        opc     = 3'b000;
        f2      = 2'b00;
        case (req_op)
            5'd0, 5'd1, 5'd2, 5'd3: f2 = req_op[1:0];
            5'd4, 5'd5, 5'd6: begin opc = 3'b001; f2 = req_op[1:0]; end
            5'd7:  opc = 3'b010;
            5'd8:  begin opc = 3'b010; f2 = 2'b01; end
            5'd9:  begin opc = 3'b010; f2 = 2'b10; end
            5'd10: opc = 3'b011;
            5'd11: begin opc = 3'b011; f2 = 2'b01; end
            5'd12: opc = 3'b100;
            5'd13: begin opc = 3'b100; f2 = 2'b01; end
            5'd14: opc = 3'b101;
            5'd15: begin opc = 3'b101; f2 = 2'b01; end
            5'd16: begin opc = 3'b101; f2 = 2'b10; end
            default: illegal = 1'b1;
        endcase
        // Illegal ids fall through as addp with every field passed unmasked
        jump = (opc == 3'b101) && (f2 == 2'b10);
        imm  = (!illegal && opc[2:1] == 2'b00) ? 15'd0 : req_imm;
        rs2  = (opc[2:1] == 2'b01 || jump) ? 4'd0 : req_rs2;
        rs1  = jump ? 4'd0 : req_rs1;
        rd   = (opc == 3'b100 || opc == 3'b101) ? 4'd0 : req_rd;
        word = {imm, rs2, rs1, rd, f2, opc};
    end

`ifdef ILLEGAL_TRAP_EN
    assign drop = illegal;
`else
    assign drop = 1'b0;
`endif

    assign req_ready   = cnt_q != LW'(DEPTH);
    assign mem_we      = cnt_q != '0;
    assign mem_addr    = ptr_q;
    assign mem_wdata   = mem_we ? fifo_q[rp_q] : 32'd0;
    assign wr_count    = wc_q;
    assign fifo_level  = cnt_q;
    assign err_illegal = err_q;
    assign acc         = req_valid && req_ready;
    assign push        = acc && !drop;
    assign pop         = mem_we && mem_ready;

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wp_q] = word;
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + LW'(push) - LW'(pop);
        // A load overrides the increment; a write retiring this cycle already used the old address
        ptr_d = base_load ? base_addr : ptr_q + ADDR_W'(pop);
        wc_d  = base_load ? 16'd0 : (pop && wc_q != 16'hFFFF) ? wc_q + 16'd1 : wc_q;
        err_d = err_q || (acc && drop);
    end

    always_ff @(posedge clk) fifo_q <= fifo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ptr_q <= '0;
            wc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            wc_q  <= wc_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_instr_encoder_loader;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [4:0]        req_op;
    logic [3:0]        req_rd, req_rs1, req_rs2;
    logic [14:0]       req_imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_ready, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       wr_count;
    logic [2:0]        fifo_level;
    logic              err_illegal;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                failures = 0;
    logic [ADDR_W-1:0] exp_ptr;
    int                exp_wc;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .base_load(base_load), .base_addr(base_addr),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .wr_count(wr_count), .fifo_level(fifo_level),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=no_write", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", mem_wdata, e.d);
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [14:0] imm, input logic [31:0] w,
                        input bit pushes);
        int n = 0;
        req_valid = 1'b1;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout req_ready=0 required=1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (pushes) begin
            sb.push_back(exp_t'{a: exp_ptr, d: w});
            exp_ptr++;
            exp_wc++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_level != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_imm = '0; base_load = 1'b0; base_addr = '0; mem_ready = 1'b0;
        exp_ptr = '0; exp_wc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_wc", 32'(wr_count), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        send(5'd0, 4'd1, 4'd2, 4'd3, 15'd5, 32'h0000_6420, 1'b1);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_level", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        chk("t1_hold_data", mem_wdata, 32'h0000_6420);
        chk("t1_hold_addr", 32'(mem_addr), 32'd0);
        mem_ready = 1'b1;
        drain();
        chk("t1_wc", 32'(wr_count), 32'(exp_wc));

        send(5'd11, 4'd4, 4'd1, 4'd7, 15'd8, 32'h0010_028B, 1'b1);
        send(5'd1, 4'd15, 4'd15, 4'd15, 15'h7FFF, 32'h0001_FFE8, 1'b1);
        send(5'd12, 4'd5, 4'd3, 4'd2, 15'h10, 32'h0020_4604, 1'b1);
        send(5'd16, 4'd1, 4'd2, 4'd3, 15'h7FFF, 32'hFFFE_0015, 1'b1);
        send(5'd15, 4'd9, 4'd4, 4'd6, 15'd3, 32'h0006_C80D, 1'b1);
        send(5'd5, 4'd2, 4'd3, 4'd4, 15'd9, 32'h0000_8649, 1'b1);
        send(5'd9, 4'd3, 4'd1, 4'd5, 15'h100, 32'h0200_0272, 1'b1);
        drain();
        chk("t2_wc", 32'(wr_count), 32'(exp_wc));

        mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(5'd4, 4'(i), 4'd0, 4'd0, 15'd0, 32'(1 | (i << 5)), 1'b1);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        req_valid = 1'b1; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("full_no_accept", 32'(fifo_level), 32'(DEPTH - 1));
        drain();
        chk("t3_wc", 32'(wr_count), 32'(exp_wc));

        base_load = 1'b1; base_addr = 10'h3FF;
        @(posedge clk); #1;
        base_load = 1'b0;
        exp_ptr = 10'h3FF; exp_wc = 0;
        chk("base_wc", 32'(wr_count), 32'd0);
        chk("base_addr", 32'(mem_addr), 32'h3FF);
        send(5'd10, 4'd2, 4'd3, 4'd4, 15'd1, 32'h0002_0643, 1'b1);
        send(5'd13, 4'd6, 4'd7, 4'd8, 15'd2, 32'h0005_0E0C, 1'b1);
        drain();
        chk("wrap_wc", 32'(wr_count), 32'd2);
        chk("wrap_addr", 32'(mem_addr), 32'd1);

`ifdef ILLEGAL_TRAP_EN
        send(5'd20, 4'd1, 4'd2, 4'd3, 15'd5, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("illegal_err", 32'(err_illegal), 32'd1);
        chk("illegal_level", 32'(fifo_level), 32'd0);
`else
        send(5'd20, 4'd1, 4'd2, 4'd3, 15'd5, 32'h000A_6420, 1'b1);
        drain();
        chk("illegal_err", 32'(err_illegal), 32'd0);
`endif

        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(5'd4, 4'(i), 4'd0, 4'd0, 15'd0, 32'(1 | (i << 5)), 1'b1);
        chk("t6_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_we", 32'(mem_we), 32'd0);
        chk("t6_level_rst", 32'(fifo_level), 32'd0);
        chk("t6_wdata", mem_wdata, 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_err", 32'(err_illegal), 32'd0);
        chk("t6_wc", 32'(wr_count), 32'd0);
        sb.delete();
        exp_ptr = '0; exp_wc = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_ready", 32'(req_ready), 32'd1);
        mem_ready = 1'b1;
        send(5'd2, 4'd3, 4'd4, 4'd5, 15'd6, 32'h0000_A870, 1'b1);
        drain();
        chk("t6_post_wc", 32'(wr_count), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
